imem_wb_loader: RTL

//   Wishbone-slave controller that owns RW port 0 of the 32x512 instruction SRAM.
//   It sequences host (caravel management core) word reads and writes into SRAM
//   csb0/web0/wmask0/addr0/din0/dout0 timing, while the SLRV core keeps read port 1.
//   It provides a control register that holds the core in reset during program

---
 rtl/imem_wb_loader.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/imem_wb_loader.sv
// Wishbone slave that owns RW port 0 of the instruction SRAM.
// It turns host word reads/writes into single-cycle SRAM strobes, and exposes
// a CTRL register (core hold) and a saturating write counter (WRCNT) for load checks.
module imem_wb_loader #(
    parameter int          ADDR_W    = 9,
    parameter int          DATA_W    = 32,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    // WRCNT width; the register always reads back zero-extended to 32 bits
    parameter int          CNT_W     = 16
) (
    input  logic                  wb_clk_i,
    input  logic                  reset,
    input  logic                  wbs_cyc_i,
    input  logic                  wbs_stb_i,
    input  logic                  wbs_we_i,
    input  logic [3:0]            wbs_sel_i,
    input  logic [31:0]           wbs_adr_i,
    input  logic [31:0]           wbs_dat_i,
    output logic [31:0]           wbs_dat_o,
    output logic                  wbs_ack_o,
    output logic                  csb0,
    output logic                  web0,
    output logic [DATA_W/8-1:0]   wmask0,
    output logic [ADDR_W-1:0]     addr0,
    output logic [DATA_W-1:0]     din0,
    input  logic [DATA_W-1:0]     dout0,
    output logic                  core_hold
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_RD,
        S_RDW,
        S_ACK
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                state_q, state_d;
    logic                  ack_q, ack_d;
    logic [31:0]           dat_q, dat_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     din_q, din_d;
    logic                  hold_q, hold_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    // Address decode: the window is 4 KB; the lower half maps SRAM words
    logic       req;
    logic       is_sram;
    logic       is_ctrl;
    logic       is_cnt;
    logic [1:0] unused_adr_bits;

    assign req             = wbs_cyc_i && wbs_stb_i && (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
    assign is_sram         = !wbs_adr_i[11];
    assign is_ctrl         = (wbs_adr_i[11:2] == 10'h200);
    assign is_cnt          = (wbs_adr_i[11:2] == 10'h201);
    assign unused_adr_bits = wbs_adr_i[1:0];

    // State and all registered outputs; reset abandons any access and raises csb0
    always_ff @(posedge wb_clk_i) begin
        if (reset) begin
            state_q <= S_IDLE;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            hold_q  <= 1'b1;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and next register values; SRAM strobes default inactive
    always_comb begin
        state_d = state_q;
        ack_d   = 1'b0;
        dat_d   = dat_q;
        csb_d   = 1'b1;
        web_d   = 1'b1;
        wmask_d = '0;
        addr_d  = addr_q;
        din_d   = din_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                dat_d = '0;
                if (req) begin
                    if (is_sram) begin
                        addr_d = wbs_adr_i[ADDR_W+1:2];
                        if (wbs_we_i) begin
                            state_d = S_WR;
                            din_d   = wbs_dat_i;
                            // Writes only reach the SRAM while the core is held
                            if (hold_q) begin
                                csb_d   = 1'b0;
                                web_d   = 1'b0;
                                wmask_d = wbs_sel_i;
                                if ((wbs_sel_i != 4'h0) && (cnt_q != CNT_MAX)) begin
                                    cnt_d = cnt_q + 1'b1;
                                end
                            end
                        end else begin
                            state_d = S_RD;
                            csb_d   = 1'b0;
                        end
                    end else begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        if (wbs_we_i) begin
                            if (is_ctrl) hold_d = wbs_dat_i[0];
                            if (is_cnt)  cnt_d  = '0;
                        end else if (is_ctrl) begin
                            dat_d = {31'b0, hold_q};
                        end else if (is_cnt) begin
                            dat_d = {{(32-CNT_W){1'b0}}, cnt_q};
                        end
                    end
                end
            end
            S_WR: begin
                // A dropped cycle still lets the strobe finish but gets no ack
                if (wbs_cyc_i) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RD: begin
                state_d = wbs_cyc_i ? S_RDW : S_IDLE;
            end
            S_RDW: begin
                // SRAM data is valid now, one cycle after the read strobe
                if (wbs_cyc_i) begin
                    state_d = S_ACK;
                    ack_d   = 1'b1;
                    dat_d   = dout0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
                dat_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;
    assign csb0      = csb_q;
    assign web0      = web_q;
    assign wmask0    = wmask_q;
    assign addr0     = addr_q;
    assign din0      = din_q;
    assign core_hold = hold_q;

endmodule
